// File: rtl/lsu_pkg_r32i.sv
// Shared types and helpers for the RV32I load/store unit: FSM states,
// funct3 encodings and legality/alignment classification.
package lsu_pkg_r32i;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } lsuState_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic funct3Legal(input logic [2:0] f3, input logic isWrite);
        if (isWrite) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addrLo);
        case (f3[1:0])
            2'b01:   return addrLo[0];
            2'b10:   return addrLo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_r32i.sv
// Combinational lane logic: extracts/extends a loaded byte or halfword and
// merges a sub-word store into the previously read RAM word.
module lsu_align_r32i
    import lsu_pkg_r32i::*;
#(
    parameter int dataW = 32
) (
    input  logic [dataW-1:0] rdWord,
    input  logic [dataW-1:0] oldWord,
    input  logic [dataW-1:0] storeData,
    input  logic [1:0]       byteOff,
    input  logic [2:0]       funct3,
    output logic [dataW-1:0] loadVal,
    output logic [dataW-1:0] mergeWord
);

    function automatic logic [dataW-1:0] loadExtract(input logic [dataW-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{(dataW-8){b[7]}}, b};
            F3_BU:   return {{(dataW-8){1'b0}}, b};
            F3_H:    return {{(dataW-16){h[15]}}, h};
            F3_HU:   return {{(dataW-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [dataW-1:0] storeMerge(input logic [dataW-1:0] old,
                                                    input logic [dataW-1:0] sd,
                                                    input logic [1:0] off,
                                                    input logic [2:0] f3);
        logic [dataW-1:0] r;
        r = old;
        case (f3)
            F3_B: r[{off, 3'b000} +: 8] = sd[7:0];
            F3_H: begin
                if (off[1]) r[31:16] = sd[15:0];
                else        r[15:0]  = sd[15:0];
            end
            default: r = sd;
        endcase
        return r;
    endfunction

    assign loadVal   = loadExtract(rdWord, byteOff, funct3);
    assign mergeWord = storeMerge(oldWord, storeData, byteOff, funct3);

endmodule

// File: rtl/lsu_r32i.sv
// RV32I load/store unit: arbitrates for the shared RAM port, performs
// sub-word stores by read-modify-write, and flags misaligned/illegal accesses.
module lsu_r32i
    import lsu_pkg_r32i::*;
#(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   MemReq,
    input  logic                   MemWrite,
    input  logic [2:0]             Funct3,
    input  logic [dataW-1:0]       EffAddr,
    input  logic [dataW-1:0]       StoreData,
    input  logic                   RAMGrant,
    input  logic [dataW-1:0]       RAMIn,
    output logic                   RAMReq,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic                   RAMWriteControl,
    output logic [dataW-1:0]       RAMDataOut,
    output logic [dataW-1:0]       LoadData,
    output logic                   LSUStall,
    output logic                   LSUDone,
    output logic                   MisalignFault,
    output logic [2:0]             dbgState
);

    lsuState_t               state, nextState;
    logic [RAMAddrSize-1:0]  addrQ;
    logic [dataW-1:0]        storeQ;
    logic [dataW-1:0]        oldWordQ;
    logic [2:0]              funct3Q;
    logic                    writeQ;
    logic [dataW-1:0]        loadVal;
    logic [dataW-1:0]        mergeWord;
    logic [RAMAddrSize-1:0]  wordAddr;
    logic                    accept;

    // Address bits above the RAM range are dropped without a fault.
    logic addrUnused;
    assign addrUnused = ^EffAddr[dataW-1:RAMAddrSize];

    assign accept   = (state == IDLE) && MemReq;
    assign wordAddr = {addrQ[RAMAddrSize-1:2], 2'b00};
    assign dbgState = state;

    lsu_align_r32i #(.dataW(dataW)) u_align (
        .rdWord    (RAMIn),
        .oldWord   (oldWordQ),
        .storeData (storeQ),
        .byteOff   (addrQ[1:0]),
        .funct3    (funct3Q),
        .loadVal   (loadVal),
        .mergeWord (mergeWord)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addrQ    <= '0;
            storeQ   <= '0;
            oldWordQ <= '0;
            funct3Q  <= '0;
            writeQ   <= 1'b0;
            LoadData <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                addrQ   <= EffAddr[RAMAddrSize-1:0];
                storeQ  <= StoreData;
                funct3Q <= Funct3;
                writeQ  <= MemWrite;
            end
            if (state == READ && RAMGrant) begin
                if (writeQ) oldWordQ <= RAMIn;
                else        LoadData <= loadVal;
            end
        end
    end

    always_comb begin
        nextState       = state;
        RAMReq          = 1'b0;
        RAMAddr         = '0;
        RAMWriteControl = 1'b0;
        RAMDataOut      = '0;
        LSUStall        = 1'b0;
        LSUDone         = 1'b0;
        MisalignFault   = 1'b0;
        case (state)
            IDLE: begin
                if (MemReq) begin
                    LSUStall = 1'b1;
                    if (!funct3Legal(Funct3, MemWrite) || misaligned(Funct3, EffAddr[1:0]))
                        nextState = FAULT;
                    else if (MemWrite && Funct3 == F3_W)
                        nextState = WRITE;
                    else
                        nextState = READ;
                end
            end
            READ: begin
                RAMReq   = 1'b1;
                RAMAddr  = wordAddr;
                LSUStall = 1'b1;
                if (RAMGrant) nextState = writeQ ? WRITE : DONE;
            end
            WRITE: begin
                RAMReq          = 1'b1;
                RAMAddr         = wordAddr;
                RAMDataOut      = mergeWord;
                RAMWriteControl = RAMGrant;
                LSUStall        = 1'b1;
                if (RAMGrant) nextState = DONE;
            end
            DONE: begin
                LSUDone   = 1'b1;
                nextState = IDLE;
            end
            FAULT: begin
                MisalignFault = 1'b1;
                nextState     = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_r32i.sv
// Directed bench for lsu_r32i with a RAM model, response scoreboard,
// latency/write-count checks and an asynchronous reset mid-write.
module tb_lsu_r32i;
    import lsu_pkg_r32i::*;

    logic        clock;
    logic        reset;
    logic        MemReq;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] EffAddr;
    logic [31:0] StoreData;
    logic        RAMGrant;
    logic [31:0] RAMIn;
    logic        RAMReq;
    logic [15:0] RAMAddr;
    logic        RAMWriteControl;
    logic [31:0] RAMDataOut;
    logic [31:0] LoadData;
    logic        LSUStall;
    logic        LSUDone;
    logic        MisalignFault;
    logic [2:0]  dbgState;

    lsu_r32i #(.dataW(32), .RAMAddrSize(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .MemReq          (MemReq),
        .MemWrite        (MemWrite),
        .Funct3          (Funct3),
        .EffAddr         (EffAddr),
        .StoreData       (StoreData),
        .RAMGrant        (RAMGrant),
        .RAMIn           (RAMIn),
        .RAMReq          (RAMReq),
        .RAMAddr         (RAMAddr),
        .RAMWriteControl (RAMWriteControl),
        .RAMDataOut      (RAMDataOut),
        .LoadData        (LoadData),
        .LSUStall        (LSUStall),
        .LSUDone         (LSUDone),
        .MisalignFault   (MisalignFault),
        .dbgState        (dbgState)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: combinational read, write on the rising edge
    logic [31:0] ram [0:16383];
    int wrCount = 0;
    int reqCount = 0;
    assign RAMIn = ram[RAMAddr[15:2]];
    always @(posedge clock) begin
        if (RAMWriteControl) begin
            ram[RAMAddr[15:2]] <= RAMDataOut;
            wrCount++;
        end
        if (RAMReq) reqCount++;
    end

    int total = 0;
    int bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] monE;
    logic [31:0] expLoad = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: bit 32 = fault expected, [31:0] = LoadData expected
    always @(negedge clock) begin
        if (reset && (LSUDone || MisalignFault)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_response: done=%b fault=%b expected none", LSUDone, MisalignFault);
            end else begin
                monE = exp_q.pop_front();
                check("resp_fault", {31'b0, MisalignFault}, {31'b0, monE[32]});
                check("resp_done", {31'b0, LSUDone}, {31'b0, ~monE[32]});
                check("resp_loaddata", LoadData, monE[31:0]);
            end
        end
    end

    // driver: issue one request and hold MemReq until completion
    task automatic doOp(input string name, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic fault, input logic [31:0] newLoad,
                        input int expLat, input int lowCycles);
        int lat;
        logic seen;
        int w0;
        int r0;
        @(posedge clock);
        #1;
        w0 = wrCount;
        r0 = reqCount;
        if (!fault && !wr) expLoad = newLoad;
        exp_q.push_back({fault, expLoad});
        MemReq    = 1'b1;
        MemWrite  = wr;
        Funct3    = f3;
        EffAddr   = addr;
        StoreData = data;
        if (lowCycles > 0) RAMGrant = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clock);
            lat++;
            #1;
            if (lowCycles > 0 && lat <= lowCycles) begin
                check({name, "_stall_wait"}, {31'b0, LSUStall}, 32'd1);
                check({name, "_we_wait"}, {31'b0, RAMWriteControl}, 32'd0);
                if (lat == lowCycles) RAMGrant = 1'b1;
            end
            if (LSUDone || MisalignFault) seen = 1'b1;
        end
        MemReq = 1'b0;
        RAMGrant = 1'b1;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no completion after %0d cycles, required %0d", name, lat, expLat);
        end else begin
            check({name, "_latency"}, lat, expLat);
        end
        check({name, "_writes"}, wrCount - w0, (fault || !wr) ? 32'd0 : 32'd1);
        if (fault) check({name, "_ramreqs"}, reqCount - r0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[32'h100 >> 2] = 32'h8000_7F80;
        ram[32'h200 >> 2] = 32'hA5A5_A5A5;
        ram[32'h204 >> 2] = 32'h1122_3344;
        ram[32'h400 >> 2] = 32'h5566_7788;
        reset = 1'b0;
        MemReq = 1'b0;
        MemWrite = 1'b0;
        Funct3 = 3'b000;
        EffAddr = 32'h0;
        StoreData = 32'h0;
        RAMGrant = 1'b1;
        #22;
        check("rst_state", {29'b0, dbgState}, {29'b0, IDLE});
        check("rst_loaddata", LoadData, 32'h0);
        check("rst_ctrl", {27'b0, RAMReq, RAMWriteControl, LSUStall, LSUDone, MisalignFault}, 32'h0);
        check("rst_ramaddr", {16'b0, RAMAddr}, 32'h0);
        check("rst_ramdata", RAMDataOut, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        doOp("lb_100",  1'b0, F3_B,  32'h100, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0);
        doOp("lbu_100", 1'b0, F3_BU, 32'h100, 32'h0, 1'b0, 32'h0000_0080, 2, 0);
        doOp("lb_101",  1'b0, F3_B,  32'h101, 32'h0, 1'b0, 32'h0000_007F, 2, 0);
        doOp("lh_102",  1'b0, F3_H,  32'h102, 32'h0, 1'b0, 32'hFFFF_8000, 2, 0);
        doOp("lhu_102", 1'b0, F3_HU, 32'h102, 32'h0, 1'b0, 32'h0000_8000, 2, 0);
        doOp("lh_103",  1'b0, F3_H,  32'h103, 32'h0, 1'b1, 32'h0, 1, 0);

        doOp("sb_205", 1'b1, F3_B, 32'h205, 32'h0000_00AB, 1'b0, 32'h0, 3, 0);
        check("sb_205_ram", ram[32'h204 >> 2], 32'h1122_AB44);
        doOp("sh_206", 1'b1, F3_H, 32'h206, 32'h0000_CDEF, 1'b0, 32'h0, 3, 0);
        check("sh_206_ram", ram[32'h204 >> 2], 32'hCDEF_AB44);

        doOp("sw_300", 1'b1, F3_W, 32'h300, 32'hDEAD_BEEF, 1'b0, 32'h0, 4, 3);
        check("sw_300_ram", ram[32'h300 >> 2], 32'hDEAD_BEEF);
        doOp("lw_300", 1'b0, F3_W, 32'h300, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0);

        doOp("ld_f011", 1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0);
        doOp("st_f100", 1'b1, 3'b100, 32'h200, 32'h1234_5678, 1'b1, 32'h0, 1, 0);
        check("st_f100_ram", ram[32'h200 >> 2], 32'hA5A5_A5A5);
        doOp("sw_302", 1'b1, F3_W, 32'h302, 32'h1234_5678, 1'b1, 32'h0, 1, 0);
        check("sw_302_ram", ram[32'h300 >> 2], 32'hDEAD_BEEF);
        doOp("lw_trunc", 1'b0, F3_W, 32'h0001_0100, 32'h0, 1'b0, 32'h8000_7F80, 2, 0);

        // reset lands while an SB is driving its write
        @(posedge clock);
        #1;
        MemReq = 1'b1;
        MemWrite = 1'b1;
        Funct3 = F3_B;
        EffAddr = 32'h400;
        StoreData = 32'h0000_0099;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rmw_in_write", {29'b0, dbgState}, {29'b0, WRITE});
        check("rmw_we_high", {31'b0, RAMWriteControl}, 32'd1);
        #2;
        reset = 1'b0;
        MemReq = 1'b0;
        #1;
        check("rmw_we_dropped", {31'b0, RAMWriteControl}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        expLoad = 32'h0;
        #1;
        check("rmw_ram_kept", ram[32'h400 >> 2], 32'h5566_7788);
        check("rel_state", {29'b0, dbgState}, {29'b0, IDLE});
        check("rel_loaddata", LoadData, 32'h0);
        check("rel_ctrl", {27'b0, RAMReq, RAMWriteControl, LSUStall, LSUDone, MisalignFault}, 32'h0);
        doOp("lw_400", 1'b0, F3_W, 32'h400, 32'h0, 1'b0, 32'h5566_7788, 2, 0);

        repeat (3) @(posedge clock);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_r32i.md
Name: lsu_r32i

Overview:
- Load/store unit between the decoder/ALU and the single-port zeroDelayRAM data path.
- Adds byte and halfword loads with sign or zero extension, and sub-word stores via a read-modify-write FSM.
- Detects misaligned and illegal accesses.
- Raises a stall to the PC while an access is in flight; arbitrates for the shared RAM port with a request/grant handshake.

Parameters:
- dataW, 32, datapath width.
- RAMAddrSize, 16, width of the RAM byte-address bus.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReq  in  1  decoder has a load/store in its execute slot; held high until LSUDone or MisalignFault.
- MemWrite  in  1  1 = store, 0 = load; qualified by MemReq.
- Funct3  in  3  RV32I funct3: loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010.
- EffAddr  in  dataW  effective byte address (ALUResult).
- StoreData  in  dataW  rs2 value.
- RAMGrant  in  1  RAM port is owned by the LSU this cycle.
- RAMIn  in  dataW  word read from RAM (combinational read).
- RAMReq  out  1  LSU requests the RAM port.
- RAMAddr  out  RAMAddrSize  word-aligned byte address; bits [1:0] are always 0.
- RAMWriteControl  out  1  RAM write enable.
- RAMDataOut  out  dataW  word to write.
- LoadData  out  dataW  extended load result, registered.
- LSUStall  out  1  freeze the PC and instruction.
- LSUDone  out  1  one-cycle completion pulse.
- MisalignFault  out  1  one-cycle fault pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including LoadData.
  - Internal address/data registers are cleared.
  - A write in progress is abandoned and RAMWriteControl drops immediately.
- States: IDLE, READ, WRITE, DONE, FAULT.
- IDLE:
  - A request is accepted only in IDLE, only when MemReq=1.
  - On acceptance, EffAddr, StoreData, Funct3 and MemWrite are latched.
  - LSUStall is combinationally 1 in the accept cycle.
  - Next state:
    - Illegal funct3 (loads 011/110/111, stores 011–111) or misaligned access → FAULT.
    - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]≠00.
    - LB/LH/LW/LBU/LHU, SB, SH → READ.
    - SW → WRITE.
- READ:
  - RAMReq=1; RAMAddr={addr[RAMAddrSize-1:2],2'b00}.
  - While RAMGrant=0, hold the state.
  - When RAMGrant=1, capture RAMIn.
    - Load: extract the lane and extend into LoadData, then go to DONE.
    - Sub-word store: latch the old word, then go to WRITE.
- WRITE:
  - RAMReq=1; RAMDataOut is the merged word.
  - SB replaces byte addr[1:0] with StoreData[7:0].
  - SH replaces half addr[1] with StoreData[15:0].
  - SW uses StoreData unchanged.
  - RAMWriteControl = RAMGrant, so the write commits on the first granted edge; then go to DONE.
  - While not granted, hold the state with write enable low.
- DONE:
  - LSUDone=1, LSUStall=0, RAMReq=0; return to IDLE.
  - MemReq is ignored in DONE; the PC advances on this edge and the next instruction is presented in IDLE.
- FAULT:
  - MisalignFault=1 and LSUStall=0.
  - No RAM access; LoadData is unchanged.
  - Return to IDLE.
- LSUStall is 1 in IDLE-with-accept, READ and WRITE, and 0 otherwise.
- Latency with grant always high, counted from the accept edge:
  - Load: 2 cycles (READ, DONE).
  - SW: 2 cycles (WRITE, DONE).
  - SB/SH: 3 cycles (READ, WRITE, DONE).
  - Fault: 1 cycle.
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Address bits above RAMAddrSize are ignored (truncated, no fault).
- If MemWrite or Funct3 change mid-operation, the change has no effect; the latched copies are used.

Decomposition:
- Package lsu_pkg_r32i holds:
  - the state enum;
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - a function that classifies funct3 as legal/illegal per direction.
- Sub-module lsu_align_r32i is combinational, with two functions:
  - load lane select plus extension, from word, addr[1:0] and funct3;
  - store merge, from old word, StoreData, addr[1:0] and funct3.

Test Plan:
- LB, RAM word 0x8000_7F80 at 0x100, EffAddr 0x100 → LoadData 0xFFFF_FF80. Same address with LBU → 0x0000_0080. LB at 0x101 → 0x0000_007F. Each completes with LSUDone on the 2nd cycle after accept.
- LH at 0x102 on the same word → 0xFFFF_8000. LHU at 0x102 → 0x0000_8000. LH at 0x103 → MisalignFault pulse, no RAM access, LoadData unchanged.
- SB with StoreData 0x0000_00AB at 0x205, old word 0x1122_3344 → RAM 0x1122_AB44, exactly one RAMWriteControl pulse. SH 0xCDEF at 0x206 → 0xCDEF_AB44.
- SW 0xDEAD_BEEF at 0x300 with RAMGrant held low for 3 cycles → stays in WRITE with write enable 0, LSUStall=1. Commits on the first granted edge; LSUDone follows.
- Illegal funct3 011 load and 100 store → MisalignFault, no write. SW at 0x302 → fault.
- reset asserted during WRITE of an SB → RAMWriteControl drops immediately, RAM unchanged. After release, state is IDLE with all outputs 0, and a new LW completes normally.
